uart_loopback_core: RTL and testbench
=====================================

Name: uart_loopback_core

Overview:
Parametrised UART transceiver with a built-in oversampling tick generator, independent TX and RX state machines, and a runtime-selectable internal loopback path. It generalises the fixed 8-bit, fixed-rate loopback arrangement in three ways: data width, optional parity, and runtime divisor. It is the self-test and bring-up building block for the UART subsystem, and it also serves as the production transceiver when loopback=0.

Parameters:
DATA_W, 8, data bits per frame (5..9)
OVERSAMPLE, 16, ticks per bit period (even, >=4)
DIV_W, 16, width of divisor port
PARITY_EN, 0, 1 = append/check one parity bit after data
PARITY_ODD, 0, 1 = odd parity, 0 = even (ignored if PARITY_EN=0)
SYNC_STAGES, 2, rx_in synchroniser depth (>=2)

Ports:
clk  in  1  clock
nReset  in  1  asynchronous, active-low reset
divisor  in  DIV_W  clk cycles per oversample tick minus 1
loopback  in  1  1 = RX fed from internal TX line; pin tx_out parked high
tx_data  in  DATA_W  word to transmit
tx_valid  in  1  request to send tx_data
tx_busy  out  1  TX frame in progress
tx_done  out  1  one-cycle pulse at end of TX stop bit
tx_out  out  1  serial pin output, idle high
rx_in  in  1  serial pin input, asynchronous
rx_data  out  DATA_W  last received word
rx_done  out  1  one-cycle pulse when a frame completes
rx_err  out  1  framing error, valid with rx_done
rx_perr  out  1  parity error, valid with rx_done (0 when PARITY_EN=0)

Behaviour:
- Reset:
  - tx_out=1, internal TX line=1, sync flops=1.
  - tx_busy, tx_done, rx_done, rx_err, rx_perr = 0; rx_data = 0.
  - Tick counter = 0; both FSMs in IDLE.
- Tick generator:
  - Counter runs 0..divisor; the tick pulse is high for the cycle where count==divisor, then the counter reloads 0.
  - divisor=0 gives a tick every cycle.
  - A divisor change takes effect at the next wrap; if the counter is already above the new divisor, it wraps at the next cycle.
- TX FSM: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
  - Accept occurs when tx_valid=1 and tx_busy=0: tx_data is latched and tx_busy=1 from the next cycle.
  - tx_valid while busy is ignored; no queuing.
  - Each bit is held for exactly OVERSAMPLE ticks, aligned to tick boundaries. The START bit begins at the first tick after accept.
  - Data is sent LSB first; stop is 1 bit, high.
  - Parity bit = XOR of data bits, inverted if PARITY_ODD.
  - At the end of STOP, tx_done pulses and tx_busy falls in the same cycle. A new accept is legal on the following cycle.
- TX line is registered. tx_out = loopback ? 1 : TX line.
- RX source = loopback ? TX line : last sync stage of rx_in.
- RX FSM: IDLE -> START -> DATA -> [PARITY] -> STOP -> (BREAK) -> IDLE. All evaluation happens on ticks only.
  - IDLE: a low source on a tick enters START.
  - START: after OVERSAMPLE/2 ticks, re-sample. If high, this is a false start: return to IDLE with no flags. If low, continue.
  - Each later bit is sampled OVERSAMPLE ticks after the previous sample (mid-bit). Data bits are shifted LSB first.
  - STOP sample:
    - rx_data is updated with the received word.
    - rx_done pulses for one clk.
    - rx_err = (stop==0).
    - rx_perr = parity mismatch.
    - Flags are only meaningful while rx_done=1 and read 0 otherwise.
  - Stop low: enter BREAK and wait for the source high on a tick before IDLE. A held-low line yields exactly one rx_done.
  - rx_data holds its value between frames.
- Toggling loopback mid-frame switches both paths immediately. The in-flight frame may complete with rx_err/rx_perr; neither FSM may lock up. Both are back in IDLE within one frame time once the source is idle high.
- TX and RX are fully independent: simultaneous tx_done and rx_done are legal.
- nReset asserted mid-frame aborts both FSMs instantly, with all outputs at reset values.

Test Plan:
- loopback=1, divisor=1, defaults; send 0xA5 -> rx_done with rx_data=0xA5, rx_err=0, rx_perr=0. tx_done lands 320 +/-2 cycles after accept. tx_out stays 1 throughout.
- Back-to-back: assert tx_valid with 0x00, 0xFF, 0x3C re-asserted on the cycle after each tx_done -> three rx_done pulses with those values in order. No idle gap longer than 1 tick between frames.
- PARITY_EN=1, PARITY_ODD=1, loopback=0; drive rx_in with 0x55 and a wrong parity bit -> rx_done with rx_data=0x55, rx_perr=1, rx_err=0. Correct parity gives rx_perr=0.
- loopback=0; drive rx_in low through the stop bit for 3 frame times, then high -> exactly one rx_done with rx_err=1 and rx_data=0x00. The next valid frame 0x81 is received cleanly.
- loopback=0; rx_in low glitch of OVERSAMPLE/4 ticks -> no rx_done. A following frame 0x12 is received correctly.
- Assert nReset mid-DATA of a TX frame -> tx_busy=0, tx_out=1, no tx_done/rx_done. After release, 0xC3 sends and loops back correctly.

Source files
------------

// File: rtl/uart_loopback_core.sv
// rtl/uart_loopback_core.sv - UART transceiver with oversampling tick generator and internal loopback
//
// Purpose: parametrised UART (DATA_W data bits, optional parity, 1 stop bit).
//   A free-running tick generator produces one tick every divisor+1 clocks.
//   Each bit spans OVERSAMPLE ticks. TX and RX are independent FSMs.
//   With loopback=1 the RX path listens to the internal TX line and the
//   tx_out pin is parked high.
// Ports:
//   clk, nReset          clock, asynchronous active-low reset
//   divisor              clk cycles per oversample tick minus 1
//   loopback             1 = RX fed from internal TX line, tx_out held high
//   tx_data, tx_valid    word to send and send request (accepted when !tx_busy)
//   tx_busy, tx_done     frame in progress, one-cycle end-of-frame pulse
//   tx_out               serial output pin, idle high
//   rx_in                serial input pin, asynchronous
//   rx_data              last received word
//   rx_done              one-cycle pulse per completed frame
//   rx_err, rx_perr      framing / parity error, qualified by rx_done
module uart_loopback_core #(
  parameter int DATA_W      = 8,
  parameter int OVERSAMPLE  = 16,
  parameter int DIV_W       = 16,
  parameter int PARITY_EN   = 0,
  parameter int PARITY_ODD  = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              nReset,
  input  logic [DIV_W-1:0]  divisor,
  input  logic              loopback,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_busy,
  output logic              tx_done,
  output logic              tx_out,
  input  logic              rx_in,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_done,
  output logic              rx_err,
  output logic              rx_perr
);

  localparam int OS_W = $clog2(OVERSAMPLE);
  localparam int BC_W = $clog2(DATA_W + 1);
  localparam logic [OS_W-1:0] OS_LAST = OS_W'(OVERSAMPLE - 1);
  localparam logic [OS_W-1:0] OS_HALF = OS_W'(OVERSAMPLE / 2 - 1);
  localparam logic [BC_W-1:0] BIT_LAST = BC_W'(DATA_W - 1);
  localparam logic ODD = (PARITY_ODD != 0);

  // ---------------------------------------------------------------- ticks
  logic [DIV_W-1:0] div_cnt;
  logic             tick;

  // ">=" rather than "==" so a divisor lowered below the running count
  // wraps on the next cycle instead of running through the whole range.
  assign tick = (div_cnt >= divisor);

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) div_cnt <= '0;
    else         div_cnt <= tick ? '0 : div_cnt + DIV_W'(1);
  end

  // ------------------------------------------------------------------- TX
  typedef enum logic [2:0] {
    TX_IDLE, TX_WAIT, TX_START, TX_DATA, TX_PAR, TX_STOP
  } tx_state_t;

  tx_state_t         tx_state, tx_state_n;
  logic [OS_W-1:0]   tx_os, tx_os_n;
  logic [BC_W-1:0]   tx_bit, tx_bit_n;
  logic [DATA_W-1:0] tx_shift, tx_shift_n;
  logic              tx_par, tx_par_n;
  logic              tx_line, tx_line_n;
  logic              tx_done_n;
  logic              tx_bit_end;

  assign tx_busy    = (tx_state != TX_IDLE);
  assign tx_out     = loopback | tx_line;
  assign tx_bit_end = tick && (tx_os == OS_LAST);

  always_comb begin
    tx_state_n = tx_state;
    tx_os_n    = tx_os;
    tx_bit_n   = tx_bit;
    tx_shift_n = tx_shift;
    tx_par_n   = tx_par;
    tx_line_n  = tx_line;
    tx_done_n  = 1'b0;

    if (tick && tx_state != TX_IDLE && tx_state != TX_WAIT)
      tx_os_n = tx_bit_end ? '0 : tx_os + OS_W'(1);

    unique case (tx_state)
      TX_IDLE: begin
        if (tx_valid) begin
          tx_shift_n = tx_data;
          tx_par_n   = (^tx_data) ^ ODD;
          tx_state_n = TX_WAIT;
        end
      end
      // Accepted, waiting for the tick that opens the start bit.
      TX_WAIT: begin
        if (tick) begin
          tx_state_n = TX_START;
          tx_line_n  = 1'b0;
          tx_os_n    = '0;
        end
      end
      TX_START: begin
        if (tx_bit_end) begin
          tx_state_n = TX_DATA;
          tx_bit_n   = '0;
          tx_line_n  = tx_shift[0];
        end
      end
      TX_DATA: begin
        if (tx_bit_end) begin
          if (tx_bit == BIT_LAST) begin
            if (PARITY_EN != 0) begin
              tx_state_n = TX_PAR;
              tx_line_n  = tx_par;
            end else begin
              tx_state_n = TX_STOP;
              tx_line_n  = 1'b1;
            end
          end else begin
            tx_bit_n   = tx_bit + BC_W'(1);
            tx_shift_n = tx_shift >> 1;
            tx_line_n  = tx_shift[1];
          end
        end
      end
      TX_PAR: begin
        if (tx_bit_end) begin
          tx_state_n = TX_STOP;
          tx_line_n  = 1'b1;
        end
      end
      TX_STOP: begin
        if (tx_bit_end) begin
          tx_state_n = TX_IDLE;
          tx_done_n  = 1'b1;
        end
      end
      default: tx_state_n = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      tx_state <= TX_IDLE;
      tx_os    <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
      tx_par   <= 1'b0;
      tx_line  <= 1'b1;
      tx_done  <= 1'b0;
    end else begin
      tx_state <= tx_state_n;
      tx_os    <= tx_os_n;
      tx_bit   <= tx_bit_n;
      tx_shift <= tx_shift_n;
      tx_par   <= tx_par_n;
      tx_line  <= tx_line_n;
      tx_done  <= tx_done_n;
    end
  end

  // ------------------------------------------------------------------- RX
  logic [SYNC_STAGES-1:0] sync;
  logic                   rx_src;

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) sync <= '1;
    else         sync <= {sync[SYNC_STAGES-2:0], rx_in};
  end

  assign rx_src = loopback ? tx_line : sync[SYNC_STAGES-1];

  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA, RX_PAR, RX_STOP, RX_BREAK
  } rx_state_t;

  rx_state_t         rx_state, rx_state_n;
  logic [OS_W-1:0]   rx_os, rx_os_n;
  logic [BC_W-1:0]   rx_bit, rx_bit_n;
  logic [DATA_W-1:0] rx_shift, rx_shift_n;
  logic              rx_par, rx_par_n;
  logic [DATA_W-1:0] rx_data_n;
  logic              rx_done_n, rx_err_n, rx_perr_n;
  logic              rx_sample;

  // The start bit is re-checked half a bit after detection; every later
  // sample is a full bit later, which lands mid-bit.
  assign rx_sample = tick && (rx_os == ((rx_state == RX_START) ? OS_HALF : OS_LAST));

  always_comb begin
    rx_state_n = rx_state;
    rx_os_n    = rx_os;
    rx_bit_n   = rx_bit;
    rx_shift_n = rx_shift;
    rx_par_n   = rx_par;
    rx_data_n  = rx_data;
    rx_done_n  = 1'b0;
    rx_err_n   = 1'b0;
    rx_perr_n  = 1'b0;

    if (tick && rx_state != RX_IDLE && rx_state != RX_BREAK)
      rx_os_n = rx_sample ? '0 : rx_os + OS_W'(1);

    unique case (rx_state)
      RX_IDLE: begin
        if (tick && !rx_src) begin
          rx_state_n = RX_START;
          rx_os_n    = '0;
        end
      end
      RX_START: begin
        if (rx_sample) begin
          rx_state_n = rx_src ? RX_IDLE : RX_DATA;
          rx_bit_n   = '0;
        end
      end
      RX_DATA: begin
        if (rx_sample) begin
          rx_shift_n = {rx_src, rx_shift[DATA_W-1:1]};
          if (rx_bit == BIT_LAST)
            rx_state_n = (PARITY_EN != 0) ? RX_PAR : RX_STOP;
          else
            rx_bit_n = rx_bit + BC_W'(1);
        end
      end
      RX_PAR: begin
        if (rx_sample) begin
          rx_par_n   = rx_src;
          rx_state_n = RX_STOP;
        end
      end
      RX_STOP: begin
        if (rx_sample) begin
          rx_data_n  = rx_shift;
          rx_done_n  = 1'b1;
          rx_err_n   = !rx_src;
          rx_perr_n  = (PARITY_EN != 0) && (rx_par ^ (^rx_shift) ^ ODD);
          // A low stop bit means the line may be held in break; wait for
          // it to return high so a long break reports only once.
          rx_state_n = rx_src ? RX_IDLE : RX_BREAK;
        end
      end
      RX_BREAK: begin
        if (tick && rx_src) rx_state_n = RX_IDLE;
      end
      default: rx_state_n = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      rx_state <= RX_IDLE;
      rx_os    <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
      rx_par   <= 1'b0;
      rx_data  <= '0;
      rx_done  <= 1'b0;
      rx_err   <= 1'b0;
      rx_perr  <= 1'b0;
    end else begin
      rx_state <= rx_state_n;
      rx_os    <= rx_os_n;
      rx_bit   <= rx_bit_n;
      rx_shift <= rx_shift_n;
      rx_par   <= rx_par_n;
      rx_data  <= rx_data_n;
      rx_done  <= rx_done_n;
      rx_err   <= rx_err_n;
      rx_perr  <= rx_perr_n;
    end
  end

endmodule

// File: tb/tb_uart_loopback_core.sv
// tb/tb_uart_loopback_core.sv - randomized self-checking bench for uart_loopback_core
module tb_uart_loopback_core;

  localparam int OS = 16;

  logic        clk = 1'b0;
  logic        nReset;
  logic [15:0] divisor;
  logic        loopback;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_busy, tx_done, tx_out;
  logic        rx_pin;
  logic [7:0]  rx_data;
  logic        rx_done, rx_err, rx_perr;

  logic        rx_pin_p;
  logic        p_tx_busy, p_tx_done, p_tx_out;
  logic [7:0]  p_rx_data;
  logic        p_rx_done, p_rx_err, p_rx_perr;

  always #5 clk = ~clk;

  uart_loopback_core dut (
    .clk(clk), .nReset(nReset), .divisor(divisor), .loopback(loopback),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_busy(tx_busy),
    .tx_done(tx_done), .tx_out(tx_out), .rx_in(rx_pin),
    .rx_data(rx_data), .rx_done(rx_done), .rx_err(rx_err), .rx_perr(rx_perr)
  );

  uart_loopback_core #(.PARITY_EN(1), .PARITY_ODD(1)) dut_p (
    .clk(clk), .nReset(nReset), .divisor(divisor), .loopback(1'b0),
    .tx_data(8'h00), .tx_valid(1'b0), .tx_busy(p_tx_busy),
    .tx_done(p_tx_done), .tx_out(p_tx_out), .rx_in(rx_pin_p),
    .rx_data(p_rx_data), .rx_done(p_rx_done), .rx_err(p_rx_err), .rx_perr(p_rx_perr)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Received-frame log: {data, err, perr}
  logic [9:0] rxq[$];
  logic [9:0] rxq_p[$];
  int         tx_done_cnt = 0;
  int         cyc = 0;
  bit         tx_low_seen = 0;

  always @(negedge clk) begin
    cyc++;
    if (rx_done)   rxq.push_back({rx_data, rx_err, rx_perr});
    if (p_rx_done) rxq_p.push_back({p_rx_data, p_rx_err, p_rx_perr});
    if (tx_done)   tx_done_cnt++;
    if (loopback && tx_out !== 1'b1) tx_low_seen = 1;
  end

  function automatic int bit_cyc();
    return OS * (int'(divisor) + 1);
  endfunction

  task automatic send_tx(input logic [7:0] w);
    int b = 0;
    @(negedge clk);
    while (tx_busy && b < 4000) begin @(negedge clk); b++; end
    if (tx_busy) check_eq("tx_busy_timeout", tx_busy, 0);
    tx_data  = w;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic wait_tx_idle();
    int b = 0;
    while (tx_busy && b < 4000) begin @(negedge clk); b++; end
    if (tx_busy) check_eq("tx_idle_timeout", tx_busy, 0);
  endtask

  task automatic wait_rx(input int base, input int n, input bit p, input string tag);
    int b = 15 * bit_cyc() * n + 200;
    while (((p ? rxq_p.size() : rxq.size()) < base + n) && b > 0) begin
      @(negedge clk); b--;
    end
    if (b == 0) check_eq(tag, (p ? rxq_p.size() : rxq.size()) - base, n);
  endtask

  task automatic set_line(input bit p, input logic v);
    if (p) rx_pin_p = v; else rx_pin = v;
  endtask

  // Serial frame per the line format: start, data LSB first, [parity], stop.
  task automatic drive_frame(input logic [7:0] w, input bit p, input bit par_en, input logic par_v);
    int bc = bit_cyc();
    @(negedge clk);
    set_line(p, 1'b0); repeat (bc) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      set_line(p, w[i]); repeat (bc) @(negedge clk);
    end
    if (par_en) begin set_line(p, par_v); repeat (bc) @(negedge clk); end
    set_line(p, 1'b1); repeat (bc) @(negedge clk);
  endtask

  // Reference receiver on the tx_out pin.
  task automatic decode_tx(output logic [7:0] w, output logic start_b, output logic stop_b);
    int b = 0;
    int bc = bit_cyc();
    w = '0; start_b = 1'b1; stop_b = 1'b0;
    while (tx_out !== 1'b0 && b < 4 * bc) begin @(negedge clk); b++; end
    if (tx_out !== 1'b0) begin check_eq("tx_start_timeout", tx_out, 0); return; end
    repeat (bc / 2) @(negedge clk);
    start_b = tx_out;
    for (int i = 0; i < 8; i++) begin
      repeat (bc) @(negedge clk);
      w[i] = tx_out;
    end
    repeat (bc) @(negedge clk);
    stop_b = tx_out;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] w, got_w;
    logic       sb, eb, pbit;
    logic [9:0] e;
    logic [7:0] b2b [3];
    int base, k, lat, t0, t1, t2, txc0;

    nReset = 1'b0; divisor = 16'd1; loopback = 1'b1;
    tx_data = 8'h00; tx_valid = 1'b0; rx_pin = 1'b1; rx_pin_p = 1'b1;
    repeat (3) @(negedge clk);

    check_eq("rst_tx_out",  tx_out,  1);
    check_eq("rst_tx_busy", tx_busy, 0);
    check_eq("rst_tx_done", tx_done, 0);
    check_eq("rst_rx_done", rx_done, 0);
    check_eq("rst_rx_data", rx_data, 0);
    check_eq("rst_rx_err",  rx_err,  0);
    check_eq("rst_rx_perr", rx_perr, 0);
    nReset = 1'b1;
    repeat (5) @(negedge clk);

    // Loopback 0xA5 with latency measurement
    base = rxq.size();
    tx_data = 8'hA5; tx_valid = 1'b1;
    @(negedge clk); tx_valid = 1'b0; k = 1;
    while (!tx_done && k < 2000) begin @(negedge clk); k++; end
    lat = k - 1;
    check_eq("a5_latency", (lat >= 318 && lat <= 322) ? 320 : lat, 320);
    wait_rx(base, 1, 0, "a5_rx_timeout");
    if (rxq.size() > base) begin
      e = rxq[base];
      check_eq("a5_data", e[9:2], 8'hA5);
      check_eq("a5_err",  e[1], 0);
      check_eq("a5_perr", e[0], 0);
    end
    wait_tx_idle();

    // Back-to-back frames
    b2b[0] = 8'h00; b2b[1] = 8'hFF; b2b[2] = 8'h3C;
    base = rxq.size();
    t0 = 0; t1 = 0; t2 = 0;
    @(negedge clk);
    tx_data = b2b[0]; tx_valid = 1'b1;
    @(negedge clk); tx_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      k = 0;
      while (!tx_done && k < 2000) begin @(negedge clk); k++; end
      if (!tx_done) check_eq("b2b_done_timeout", tx_done, 1);
      if (i == 0) t0 = cyc; else if (i == 1) t1 = cyc; else t2 = cyc;
      if (i < 2) begin
        tx_data = b2b[i+1]; tx_valid = 1'b1;
        @(negedge clk); tx_valid = 1'b0;
      end
    end
    check_eq("b2b_gap1", (t1 - t0 >= 320 && t1 - t0 <= 324) ? 320 : t1 - t0, 320);
    check_eq("b2b_gap2", (t2 - t1 >= 320 && t2 - t1 <= 324) ? 320 : t2 - t1, 320);
    wait_rx(base, 3, 0, "b2b_rx_timeout");
    for (int i = 0; i < 3; i++)
      if (rxq.size() > base + i) check_eq("b2b_data", rxq[base+i][9:2], b2b[i]);

    // Random words in loopback, random divisor
    for (int n = 0; n < 6; n++) begin
      wait_tx_idle();
      divisor = 16'($urandom_range(0, 3));
      repeat (8) @(negedge clk);
      w = 8'($urandom);
      base = rxq.size();
      send_tx(w);
      wait_rx(base, 1, 0, "lb_rx_timeout");
      if (rxq.size() > base) begin
        check_eq("lb_data", rxq[base][9:2], w);
        check_eq("lb_err",  rxq[base][1], 0);
      end
    end
    wait_tx_idle();
    check_eq("lb_tx_out_parked", tx_low_seen, 0);

    // Pin TX with loopback off, decoded by reference receiver
    loopback = 1'b0;
    for (int n = 0; n < 3; n++) begin
      divisor = 16'($urandom_range(0, 3));
      repeat (8) @(negedge clk);
      w = 8'($urandom);
      base = rxq.size();
      send_tx(w);
      decode_tx(got_w, sb, eb);
      check_eq("pin_tx_start", sb, 0);
      check_eq("pin_tx_data", got_w, w);
      check_eq("pin_tx_stop", eb, 1);
      wait_tx_idle();
      check_eq("pin_tx_no_rx", rxq.size() - base, 0);
    end

    // Random frames into rx_in
    for (int n = 0; n < 4; n++) begin
      divisor = 16'($urandom_range(0, 3));
      repeat (8) @(negedge clk);
      w = 8'($urandom);
      base = rxq.size();
      drive_frame(w, 0, 0, 1'b0);
      wait_rx(base, 1, 0, "pin_rx_timeout");
      if (rxq.size() > base) begin
        check_eq("pin_rx_data", rxq[base][9:2], w);
        check_eq("pin_rx_err",  rxq[base][1], 0);
      end
    end

    // Break: line held low for three frame times
    divisor = 16'd1;
    repeat (8) @(negedge clk);
    base = rxq.size();
    rx_pin = 1'b0;
    repeat (30 * bit_cyc()) @(negedge clk);
    rx_pin = 1'b1;
    repeat (3 * bit_cyc()) @(negedge clk);
    check_eq("brk_count", rxq.size() - base, 1);
    if (rxq.size() > base) begin
      e = rxq[base];
      check_eq("brk_data", e[9:2], 8'h00);
      check_eq("brk_err",  e[1], 1);
    end
    base = rxq.size();
    drive_frame(8'h81, 0, 0, 1'b0);
    wait_rx(base, 1, 0, "brk_next_timeout");
    if (rxq.size() > base) begin
      check_eq("brk_next_data", rxq[base][9:2], 8'h81);
      check_eq("brk_next_err",  rxq[base][1], 0);
    end

    // Glitch shorter than half a bit must be rejected
    base = rxq.size();
    @(negedge clk);
    rx_pin = 1'b0;
    repeat ((OS / 4) * (int'(divisor) + 1)) @(negedge clk);
    rx_pin = 1'b1;
    repeat (2 * bit_cyc()) @(negedge clk);
    check_eq("glitch_no_rx", rxq.size() - base, 0);
    drive_frame(8'h12, 0, 0, 1'b0);
    wait_rx(base, 1, 0, "glitch_next_timeout");
    if (rxq.size() > base) check_eq("glitch_next_data", rxq[base][9:2], 8'h12);

    // Odd parity instance: wrong then correct parity, then random
    base = rxq_p.size();
    drive_frame(8'h55, 1, 1, ~((^8'h55) ^ 1'b1));
    wait_rx(base, 1, 1, "par_bad_timeout");
    if (rxq_p.size() > base) begin
      e = rxq_p[base];
      check_eq("par_bad_data", e[9:2], 8'h55);
      check_eq("par_bad_err",  e[1], 0);
      check_eq("par_bad_perr", e[0], 1);
    end
    base = rxq_p.size();
    drive_frame(8'h55, 1, 1, (^8'h55) ^ 1'b1);
    wait_rx(base, 1, 1, "par_ok_timeout");
    if (rxq_p.size() > base) check_eq("par_ok_perr", rxq_p[base][0], 0);
    for (int n = 0; n < 4; n++) begin
      w = 8'($urandom);
      sb = 1'($urandom_range(0, 1));
      pbit = ((^w) ^ 1'b1) ^ sb;
      base = rxq_p.size();
      drive_frame(w, 1, 1, pbit);
      wait_rx(base, 1, 1, "par_rnd_timeout");
      if (rxq_p.size() > base) begin
        check_eq("par_rnd_data", rxq_p[base][9:2], w);
        check_eq("par_rnd_perr", rxq_p[base][0], sb);
      end
    end

    // Reset mid-DATA of a TX frame
    loopback = 1'b0;
    base = rxq.size();
    send_tx(8'($urandom));
    repeat (100) @(negedge clk);
    check_eq("rst_mid_busy_pre", tx_busy, 1);
    txc0 = tx_done_cnt;
    nReset = 1'b0;
    #1;
    check_eq("rst_mid_busy", tx_busy, 0);
    check_eq("rst_mid_tx_out", tx_out, 1);
    check_eq("rst_mid_rx_data", rx_data, 0);
    repeat (20) @(negedge clk);
    nReset = 1'b1;
    repeat (4 * bit_cyc()) @(negedge clk);
    check_eq("rst_mid_no_tx_done", tx_done_cnt - txc0, 0);
    check_eq("rst_mid_no_rx_done", rxq.size() - base, 0);
    loopback = 1'b1;
    base = rxq.size();
    send_tx(8'hC3);
    wait_rx(base, 1, 0, "rst_c3_timeout");
    if (rxq.size() > base) begin
      check_eq("rst_c3_data", rxq[base][9:2], 8'hC3);
      check_eq("rst_c3_err",  rxq[base][1], 0);
    end
    wait_tx_idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
